// File: rtl/nf10_upb_lib_pkg.sv
// rtl/nf10_upb_lib_pkg.sv - shared state encoding, LFSR taps and tkeep helper for the frame generator
package nf10_upb_lib;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIRST = 2'd1,
        ST_BODY  = 2'd2,
        ST_GAP   = 2'd3
    } gen_state_t;

    // Galois feedback mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // Byte count (1..32) to a low-justified byte-enable mask
    function automatic logic [31:0] count_to_tkeep(input logic [5:0] rem);
        logic [31:0] keep;
        keep = '0;
        for (int i = 0; i < 32; i++) begin
            keep[i] = (6'(i) < rem);
        end
        return keep;
    endfunction

endpackage

// File: rtl/frame_gen_lfsr.sv
// rtl/frame_gen_lfsr.sv - 32-bit Galois LFSR exposing the value it steps to next
module frame_gen_lfsr
    import nf10_upb_lib::*;
#(
    parameter logic [31:0] C_INIT = 32'hACE1_2468
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        step,
    output logic [31:0] next_value
);

    logic [31:0] lfsr_q;

    assign next_value = {1'b0, lfsr_q[31:1]} ^ ({32{lfsr_q[0]}} & LFSR_TAPS);

    // Advance only when the owner consumes a fresh value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= C_INIT;
        end else if (step) begin
            lfsr_q <= next_value;
        end
    end

endmodule

// File: rtl/frame_gen_axis.sv
// rtl/frame_gen_axis.sv - AXI-Stream packet source with numbered, seeded payload for the frame checker
module frame_gen_axis
    import nf10_upb_lib::*;
#(
    parameter int          C_AXIS_DATA_WIDTH     = 256,
    parameter int          C_PACKET_LENGTH_WIDTH = 14,
    parameter int          C_INPORT_WIDTH        = 3,
    parameter int          C_OUTPORT_WIDTH       = 8,
    parameter int          C_MIN_LEN             = 60,
    parameter int          C_MAX_LEN             = 1514,
    parameter int          C_GAP_BITS            = 4,
    parameter logic [31:0] C_LFSR_INIT           = 32'hACE1_2468
) (
    input  logic                             clk,
    input  logic                             axi_resetn,
    input  logic                             enable,
    input  logic [C_PACKET_LENGTH_WIDTH-1:0] cfg_fixed_len,
    input  logic [C_INPORT_WIDTH-1:0]        cfg_in_port,
    input  logic [C_OUTPORT_WIDTH-1:0]       cfg_out_port,
    output logic [C_AXIS_DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]   m_axis_tkeep,
    output logic [C_PACKET_LENGTH_WIDTH-1:0] m_axis_tuser_packet_length,
    output logic [C_INPORT_WIDTH-1:0]        m_axis_tuser_in_port,
    output logic [C_OUTPORT_WIDTH-1:0]       m_axis_tuser_out_port,
    output logic [C_INPORT_WIDTH-1:0]        m_axis_tuser_in_vport,
    output logic [C_OUTPORT_WIDTH-1:0]       m_axis_tuser_out_vport,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic                             m_axis_tlast,
    output logic [31:0]                      pkt_sent,
    output logic                             busy
);

    localparam int                PW      = C_PACKET_LENGTH_WIDTH;
    localparam int                BW      = PW - 4;
    localparam logic [10:0]       RANGE_L = 11'(C_MAX_LEN - C_MIN_LEN + 1);
    localparam logic [PW-1:0]     MIN_L   = PW'(C_MIN_LEN);

    gen_state_t            state;
    logic [31:0]           pkt_num;
    logic [31:0]           seed;
    logic [31:0]           ld_seed;
    logic [BW-1:0]         beats_left;
    logic [BW-1:0]         ld_beats;
    logic [31:0]           last_keep;
    logic [C_GAP_BITS-1:0] gap_q;
    logic [C_GAP_BITS-1:0] gap_cnt;
    logic                  pat_even;
    logic [10:0]           ld_r;
    logic [10:0]           ld_fold;
    logic [PW-1:0]         ld_len;
    logic [5:0]            ld_rem;
    logic                  hs;
    logic                  decide;
    logic                  do_load;

    frame_gen_lfsr #(
        .C_INIT(C_LFSR_INIT)
    ) u_lfsr (
        .clk       (clk),
        .rst_n     (axi_resetn),
        .step      (do_load),
        .next_value(ld_seed)
    );

    assign busy = (state != ST_IDLE);

    // Length, beat count and last-beat byte count of the packet a load would start
    always_comb begin
        ld_r     = ld_seed[26:16];
        ld_fold  = (ld_r >= RANGE_L) ? ld_r - RANGE_L : ld_r;
        ld_len   = (cfg_fixed_len != '0) ? cfg_fixed_len : MIN_L + PW'(ld_fold);
        ld_beats = {1'b0, ld_len[PW-1:5]} + BW'(|ld_len[4:0]);
        ld_rem   = (ld_len[4:0] == 5'd0) ? 6'd32 : {1'b0, ld_len[4:0]};
    end

    // A load happens wherever the FSM reaches a packet boundary and enable is high
    always_comb begin
        hs      = m_axis_tvalid && m_axis_tready;
        decide  = (state == ST_IDLE)
               || (hs && m_axis_tlast && (gap_q == '0))
               || ((state == ST_GAP) && (gap_cnt == C_GAP_BITS'(1)));
        do_load = decide && enable;
    end

    // Packet FSM; a load at the end overrides the boundary decisions in the case
    always_ff @(posedge clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state                      <= ST_IDLE;
            pkt_num                    <= '0;
            seed                       <= '0;
            beats_left                 <= '0;
            last_keep                  <= '0;
            gap_q                      <= '0;
            gap_cnt                    <= '0;
            pat_even                   <= 1'b0;
            m_axis_tdata               <= '0;
            m_axis_tkeep               <= '0;
            m_axis_tuser_packet_length <= '0;
            m_axis_tuser_in_port       <= '0;
            m_axis_tuser_out_port      <= '0;
            m_axis_tuser_in_vport      <= '0;
            m_axis_tuser_out_vport     <= '0;
            m_axis_tvalid              <= 1'b0;
            m_axis_tlast               <= 1'b0;
            pkt_sent                   <= '0;
        end else begin
            case (state)
                ST_FIRST, ST_BODY: begin
                    if (hs) begin
                        if (m_axis_tlast) begin
                            pkt_sent      <= pkt_sent + 32'd1;
                            m_axis_tlast  <= 1'b0;
                            m_axis_tvalid <= 1'b0;
                            if (gap_q != '0) begin
                                state   <= ST_GAP;
                                gap_cnt <= gap_q;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            state        <= ST_BODY;
                            m_axis_tdata <= pat_even ? {4{~seed, seed}} : {4{seed, ~seed}};
                            pat_even     <= ~pat_even;
                            beats_left   <= beats_left - BW'(1);
                            if (beats_left == BW'(1)) begin
                                m_axis_tlast <= 1'b1;
                                m_axis_tkeep <= last_keep;
                            end
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == C_GAP_BITS'(1)) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - C_GAP_BITS'(1);
                    end
                end
                default: begin
                end
            endcase

            if (do_load) begin
                state                      <= ST_FIRST;
                seed                       <= ld_seed;
                pkt_num                    <= pkt_num + 32'd1;
                m_axis_tdata               <= {pkt_num + 32'd1, {3{ld_seed, ~ld_seed}}, ld_seed};
                m_axis_tkeep               <= '1;
                m_axis_tlast               <= 1'b0;
                m_axis_tvalid              <= 1'b1;
                m_axis_tuser_packet_length <= ld_len;
                m_axis_tuser_in_port       <= cfg_in_port;
                m_axis_tuser_out_port      <= cfg_out_port;
                m_axis_tuser_in_vport      <= cfg_in_port;
                m_axis_tuser_out_vport     <= cfg_out_port;
                gap_q                      <= ld_seed[C_GAP_BITS-1:0];
                beats_left                 <= ld_beats - BW'(1);
                last_keep                  <= count_to_tkeep(ld_rem);
                pat_even                   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_frame_gen_axis.sv
// tb/tb_frame_gen_axis.sv - randomized self-checking bench for frame_gen_axis against a packet-level model
module tb_frame_gen_axis;

    localparam logic [31:0] INIT = 32'hACE1_2468;

    logic         clk = 1'b0;
    logic         axi_resetn;
    logic         enable;
    logic [13:0]  cfg_fixed_len;
    logic [2:0]   cfg_in_port;
    logic [7:0]   cfg_out_port;
    logic [255:0] m_axis_tdata;
    logic [31:0]  m_axis_tkeep;
    logic [13:0]  m_axis_tuser_packet_length;
    logic [2:0]   m_axis_tuser_in_port;
    logic [7:0]   m_axis_tuser_out_port;
    logic [2:0]   m_axis_tuser_in_vport;
    logic [7:0]   m_axis_tuser_out_vport;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic         m_axis_tlast;
    logic [31:0]  pkt_sent;
    logic         busy;

    always #5 clk = ~clk;

    frame_gen_axis dut (
        .clk                       (clk),
        .axi_resetn                (axi_resetn),
        .enable                    (enable),
        .cfg_fixed_len             (cfg_fixed_len),
        .cfg_in_port               (cfg_in_port),
        .cfg_out_port              (cfg_out_port),
        .m_axis_tdata              (m_axis_tdata),
        .m_axis_tkeep              (m_axis_tkeep),
        .m_axis_tuser_packet_length(m_axis_tuser_packet_length),
        .m_axis_tuser_in_port      (m_axis_tuser_in_port),
        .m_axis_tuser_out_port     (m_axis_tuser_out_port),
        .m_axis_tuser_in_vport     (m_axis_tuser_in_vport),
        .m_axis_tuser_out_vport    (m_axis_tuser_out_vport),
        .m_axis_tvalid             (m_axis_tvalid),
        .m_axis_tready             (m_axis_tready),
        .m_axis_tlast              (m_axis_tlast),
        .pkt_sent                  (pkt_sent),
        .busy                      (busy)
    );

    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packet-level reference model state
    logic [31:0]  m_lfsr, m_seed, m_num, m_sent;
    int           m_len, m_beats, m_gap;
    int           cur_beat;
    bit           in_pkt, stall_pending, gap_valid, rand_ready;
    logic [511:0] stall_snap;
    int           idle, exp_gap, last_beats, bad_len;
    logic [31:0]  last_keep;
    logic [15:0]  gap_seen;
    logic [31:0]  first_seed [0:1];
    int           run_idx;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    function automatic int len_of(input logic [31:0] s, input int fixed);
        int r;
        if (fixed != 0) return fixed;
        r = int'(s[26:16]);
        if (r >= 1455) r = r - 1455;
        return 60 + r;
    endfunction

    function automatic logic [255:0] beat_data(input logic [31:0] s, input logic [31:0] num, input int b);
        if (b == 1) return {num, s, ~s, s, ~s, s, ~s, s};
        if (b % 2 == 0) return {~s, s, ~s, s, ~s, s, ~s, s};
        return {s, ~s, s, ~s, s, ~s, s, ~s};
    endfunction

    function automatic logic [31:0] beat_keep(input int len, input int beats, input int b);
        int          rem;
        logic [63:0] k;
        if (b < beats) return 32'hFFFF_FFFF;
        rem = len - 32 * (beats - 1);
        k   = (64'd1 << rem) - 64'd1;
        return k[31:0];
    endfunction

    task automatic model_reset();
        m_lfsr        = INIT;
        m_num         = 0;
        m_sent        = 0;
        in_pkt        = 0;
        stall_pending = 0;
        gap_valid     = 0;
        cur_beat      = 0;
        idle          = 0;
    endtask

    task automatic observe();
        logic [511:0] snap;
        snap = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid, m_axis_tuser_packet_length,
                m_axis_tuser_in_port, m_axis_tuser_out_port, m_axis_tuser_in_vport, m_axis_tuser_out_vport};
        check("pkt_sent", pkt_sent, m_sent);
        if (stall_pending) begin
            check("stall_hold", snap, stall_snap);
            stall_pending = 0;
        end
        if (!enable) gap_valid = 0;
        if (m_axis_tvalid) begin
            if (!in_pkt) begin
                m_lfsr  = lfsr_next(m_lfsr);
                m_seed  = m_lfsr;
                m_num   = m_num + 1;
                m_len   = len_of(m_seed, int'(cfg_fixed_len));
                m_beats = (m_len + 31) / 32;
                m_gap   = int'(m_seed[3:0]);
                if (gap_valid) begin
                    check("gap_len", idle, exp_gap);
                    if (idle < 16) gap_seen[idle] = 1'b1;
                end
                if (m_num == 1) first_seed[run_idx] = m_axis_tdata[223:192];
                if (cfg_fixed_len == 0 &&
                    (m_axis_tuser_packet_length < 60 || m_axis_tuser_packet_length > 1514)) bad_len++;
                in_pkt   = 1;
                cur_beat = 1;
            end
            if (m_axis_tready) begin
                check("tdata", m_axis_tdata, beat_data(m_seed, m_num, cur_beat));
                check("tkeep", m_axis_tkeep, beat_keep(m_len, m_beats, cur_beat));
                check("tlast", m_axis_tlast, cur_beat == m_beats);
                check("tuser", {m_axis_tuser_packet_length, m_axis_tuser_in_port, m_axis_tuser_out_port,
                                m_axis_tuser_in_vport, m_axis_tuser_out_vport},
                               {14'(m_len), cfg_in_port, cfg_out_port, cfg_in_port, cfg_out_port});
                if (cur_beat == m_beats) begin
                    m_sent     = m_sent + 1;
                    in_pkt     = 0;
                    last_beats = cur_beat;
                    last_keep  = m_axis_tkeep;
                    idle       = 0;
                    exp_gap    = m_gap;
                    gap_valid  = enable;
                end
                cur_beat++;
            end else begin
                stall_snap    = snap;
                stall_pending = 1;
            end
        end else begin
            if (in_pkt) check("tvalid_held", m_axis_tvalid, 1'b1);
            idle++;
        end
    endtask

    task automatic step_cycle();
        @(posedge clk);
        #1;
        m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        observe();
    endtask

    task automatic pulse_one(input logic [13:0] len);
        cfg_fixed_len = len;
        check("idle_tvalid", m_axis_tvalid, 1'b0);
        enable = 1'b1;
        step_cycle();
        check("latency_tvalid", m_axis_tvalid, 1'b1);
        enable = 1'b0;
        repeat (30) step_cycle();
    endtask

    task automatic drain();
        enable = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!busy && !m_axis_tvalid) break;
            step_cycle();
        end
        check("drain_idle", {busy, m_axis_tvalid}, 2'b00);
    endtask

    task automatic run_packets(input int n, input int bound);
        int target;
        target = int'(m_sent) + n;
        cfg_fixed_len = 0;
        enable = 1'b1;
        for (int i = 0; i < bound && int'(m_sent) < target; i++) step_cycle();
        drain();
        check("run_pkt_sent", pkt_sent, 32'(target));
    endtask

    initial begin
        axi_resetn    = 1'b0;
        enable        = 1'b0;
        cfg_fixed_len = '0;
        cfg_in_port   = 3'($urandom);
        cfg_out_port  = 8'($urandom);
        m_axis_tready = 1'b0;
        rand_ready    = 0;
        gap_seen      = '0;
        bad_len       = 0;
        run_idx       = 0;
        last_beats    = 0;
        last_keep     = '0;
        exp_gap       = 0;
        model_reset();

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tvalid", m_axis_tvalid, 1'b0);
        check("rst_tlast", m_axis_tlast, 1'b0);
        check("rst_tkeep", m_axis_tkeep, 32'h0);
        check("rst_tdata", m_axis_tdata, 256'h0);
        check("rst_tuser", {m_axis_tuser_packet_length, m_axis_tuser_in_port, m_axis_tuser_out_port,
                            m_axis_tuser_in_vport, m_axis_tuser_out_vport}, 36'h0);
        check("rst_pkt_sent", pkt_sent, 32'h0);
        check("rst_busy", busy, 1'b0);
        axi_resetn = 1'b1;
        repeat (3) step_cycle();

        // Two-beat packet, both beats full
        pulse_one(14'd64);
        check("A_beats", last_beats, 2);
        check("A_keep", last_keep, 32'hFFFF_FFFF);
        check("A_sent", pkt_sent, 32'd1);
        check("A_busy", busy, 1'b0);

        // One byte spills into a third beat
        pulse_one(14'd65);
        check("B_beats", last_beats, 3);
        check("B_keep", last_keep, 32'h0000_0001);

        // Enable dropped during beat 2 of a 200-byte packet
        begin
            int sent0;
            sent0 = int'(m_sent);
            cfg_fixed_len = 14'd200;
            enable = 1'b1;
            for (int i = 0; i < 50; i++) begin
                step_cycle();
                if (in_pkt && cur_beat == 3) break;
            end
            enable = 1'b0;
            repeat (40) step_cycle();
            check("C_beats", last_beats, 7);
            check("C_keep", last_keep, 32'h0000_00FF);
            check("C_sent", pkt_sent, 32'(sent0 + 1));
            check("C_tvalid", m_axis_tvalid, 1'b0);
            check("C_busy", busy, 1'b0);
        end

        // Random lengths, random backpressure then full throughput
        cfg_in_port  = 3'($urandom);
        cfg_out_port = 8'($urandom);
        rand_ready   = 1;
        run_packets(150, 20000);
        rand_ready   = 0;
        run_packets(150, 10000);
        check("gap_cover", gap_seen, 16'hFFFF);
        check("len_range_violations", bad_len, 0);

        // Asynchronous reset while beat 3 is on the bus
        cfg_fixed_len = 14'd200;
        enable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step_cycle();
            if (in_pkt && cur_beat == 4) break;
        end
        #2;
        axi_resetn = 1'b0;
        #1;
        check("F_tvalid", m_axis_tvalid, 1'b0);
        check("F_tlast", m_axis_tlast, 1'b0);
        check("F_pkt_sent", pkt_sent, 32'h0);
        check("F_busy", busy, 1'b0);
        enable = 1'b0;
        model_reset();
        run_idx = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        axi_resetn = 1'b1;
        @(negedge clk);
        pulse_one(14'd64);
        check("F_first_seed", first_seed[1], first_seed[0]);
        check("F_sent", pkt_sent, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
